// File: rtl/anti_theft_ctrl.sv
// Vehicle anti-theft controller: arm/entry/alarm FSM with a seconds timer,
// reprogrammable delays, siren/status indicators and a covert fuel-pump enable.
module anti_theft_ctrl #(
    parameter int NUM_DOORS = 2,
    parameter int TW        = 4,
    parameter int TICK_DIV  = 100_000_000,
    parameter int T_ARM_DEF = 6,
    parameter int T_DRV_DEF = 8,
    parameter int T_PAS_DEF = 15,
    parameter int T_ALM_DEF = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ignition,
    input  logic                 brake,
    input  logic                 hidden_sw,
    input  logic [NUM_DOORS-1:0] door,
    input  logic                 reprogram,
    input  logic [1:0]           param_sel,
    input  logic [TW-1:0]        param_value,
    output logic                 fuel_pump,
    output logic                 status,
    output logic                 siren,
    output logic [2:0]           state,
    output logic [TW-1:0]        timer_count,
    output logic [7:0]           alarm_events
);

    typedef enum logic [2:0] {
        ARMED       = 3'd0,
        ENTRY_DELAY = 3'd1,
        ALARM       = 3'd2,
        DISARMED    = 3'd3,
        WAIT_CLOSE  = 3'd4,
        ARM_DELAY   = 3'd5
    } state_t;

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] HALF_LAST = PW'(TICK_DIV / 2 - 1);
    localparam logic [1:0]    P_ARM = 2'd0, P_DRV = 2'd1, P_PAS = 2'd2, P_ALM = 2'd3;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   tpre_q, tpre_d;
    logic [PW-1:0]   spre_q, spre_d;
    logic [PW-1:0]   hpre_q, hpre_d;
    logic [TW-1:0]   param_q [4];
    logic [TW-1:0]   param_d [4];
    logic            reprog_q;
    logic            en_q, en_d;
    logic            fuel_q, fuel_d;
    logic            status_q, status_d;
    logic            siren_q, siren_d;
    logic [7:0]      events_q, events_d;

    logic tick, expired, rep_edge, any_door;

    assign tick     = (timer_q != '0) && (tpre_q == TICK_LAST);
    assign expired  = tick && (timer_q == TW'(1));
    assign rep_edge = reprogram && !reprog_q;
    assign any_door = |door;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d = state_q;
        param_d = param_q;
        timer_d = timer_q;
        tpre_d  = '0;
        if (timer_q != '0) begin
            if (tick) timer_d = timer_q - 1'b1;
            else      tpre_d  = tpre_q + 1'b1;
        end
        if (rep_edge) begin
            if (param_value != '0) param_d[param_sel] = param_value;
            state_d = ARMED;
            timer_d = '0;
            tpre_d  = '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (any_door) begin
                        state_d = ENTRY_DELAY;
                        timer_d = door[0] ? param_q[P_DRV] : param_q[P_PAS];
                        tpre_d  = '0;
                    end
                end
                ENTRY_DELAY: begin
                    if (ignition) begin
                        state_d = DISARMED;
                        timer_d = '0;
                        tpre_d  = '0;
                    end else if (expired) begin
                        state_d = ALARM;
                        timer_d = param_q[P_ALM];
                        tpre_d  = '0;
                    end
                end
                ALARM: begin
                    if (ignition) begin
                        state_d = DISARMED;
                        timer_d = '0;
                        tpre_d  = '0;
                    end else if (any_door) begin
                        timer_d = param_q[P_ALM];
                        tpre_d  = '0;
                    end else if (expired) begin
                        state_d = ARMED;
                    end
                end
                DISARMED: begin
                    if (!ignition && door[0]) state_d = WAIT_CLOSE;
                end
                WAIT_CLOSE: begin
                    if (ignition) begin
                        state_d = DISARMED;
                    end else if (!any_door) begin
                        state_d = ARM_DELAY;
                        timer_d = param_q[P_ARM];
                        tpre_d  = '0;
                    end
                end
                ARM_DELAY: begin
                    if (ignition || any_door) begin
                        state_d = ignition ? DISARMED : WAIT_CLOSE;
                        timer_d = '0;
                        tpre_d  = '0;
                    end else if (expired) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = ARMED;
            endcase
        end
    end

    // Indicators follow the next state so they change on the same edge as the FSM.
    always_comb begin
        status_d = 1'b0;
        spre_d   = '0;
        siren_d  = 1'b0;
        hpre_d   = '0;
        events_d = events_q;
        case (state_d)
            ARMED: begin
                if (state_q == ARMED) begin
                    if (spre_q == TICK_LAST) begin
                        status_d = ~status_q;
                    end else begin
                        status_d = status_q;
                        spre_d   = spre_q + 1'b1;
                    end
                end
            end
            ENTRY_DELAY, ALARM: status_d = 1'b1;
            default: status_d = 1'b0;
        endcase
        if (state_d == ALARM) begin
            if (state_q != ALARM) begin
                siren_d = 1'b1;
                if (events_q != 8'hFF) events_d = events_q + 1'b1;
            end else if (hpre_q == HALF_LAST) begin
                siren_d = ~siren_q;
            end else begin
                siren_d = siren_q;
                hpre_d  = hpre_q + 1'b1;
            end
        end
        en_d   = ignition && (en_q || (brake && hidden_sw));
        fuel_d = en_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ARMED;
            timer_q    <= '0;
            tpre_q     <= '0;
            spre_q     <= '0;
            hpre_q     <= '0;
            // NOTE: the parameter array is a handful of flops, not RAM, so it takes reset defaults.
            param_q[0] <= TW'(T_ARM_DEF);
            param_q[1] <= TW'(T_DRV_DEF);
            param_q[2] <= TW'(T_PAS_DEF);
            param_q[3] <= TW'(T_ALM_DEF);
            reprog_q   <= 1'b0;
            en_q       <= 1'b0;
            fuel_q     <= 1'b0;
            status_q   <= 1'b0;
            siren_q    <= 1'b0;
            events_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            tpre_q   <= tpre_d;
            spre_q   <= spre_d;
            hpre_q   <= hpre_d;
            param_q  <= param_d;
            reprog_q <= reprogram;
            en_q     <= en_d;
            fuel_q   <= fuel_d;
            status_q <= status_d;
            siren_q  <= siren_d;
            events_q <= events_d;
        end
    end

    assign state        = state_q;
    assign timer_count  = timer_q;
    assign alarm_events = events_q;
    assign fuel_pump    = fuel_q;
    assign status       = status_q;
    assign siren        = siren_q;

endmodule

// File: tb/tb_anti_theft_ctrl.sv
// Bench for anti_theft_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-count reference model of the controller's rules.
module tb_anti_theft_ctrl;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ignition = 1'b0, brake = 1'b0, hidden_sw = 1'b0, reprogram = 1'b0;
    logic [1:0] door = 2'b00;
    logic [1:0] param_sel = 2'd0;
    logic [3:0] param_value = 4'd0;
    logic       fuel_pump, status, siren;
    logic [2:0] state;
    logic [3:0] timer_count;
    logic [7:0] alarm_events;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: time is tracked as remaining clock cycles, not seconds.
    int m_state, m_rem, m_events, m_armed_cnt, m_alarm_cnt;
    int m_param [4];
    bit m_rep_prev, m_latch, m_status, m_siren, m_fuel;

    anti_theft_ctrl #(.NUM_DOORS(2), .TW(4), .TICK_DIV(TD)) dut (
        .clock       (clock),
        .reset       (reset),
        .ignition    (ignition),
        .brake       (brake),
        .hidden_sw   (hidden_sw),
        .door        (door),
        .reprogram   (reprogram),
        .param_sel   (param_sel),
        .param_value (param_value),
        .fuel_pump   (fuel_pump),
        .status      (status),
        .siren       (siren),
        .state       (state),
        .timer_count (timer_count),
        .alarm_events(alarm_events)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_rem = 0; m_events = 0; m_armed_cnt = 0; m_alarm_cnt = 0;
        m_param = '{6, 8, 15, 10};
        m_rep_prev = 0; m_latch = 0; m_status = 0; m_siren = 0; m_fuel = 0;
    endtask

    task automatic model_step();
        bit rep_edge, expired, any_open;
        int prev;
        rep_edge   = reprogram && !m_rep_prev;
        m_rep_prev = reprogram;
        any_open   = (door != 2'b00);
        expired    = (m_rem == 1);
        if (m_rem > 0) m_rem--;
        prev = m_state;
        if (rep_edge) begin
            if (param_value != 0) m_param[param_sel] = param_value;
            m_state = 0; m_rem = 0;
        end else begin
            case (m_state)
                0: if (ignition) begin m_state = 3; m_rem = 0; end
                   else if (any_open) begin
                       m_state = 1; m_rem = (door[0] ? m_param[1] : m_param[2]) * TD;
                   end
                1: if (ignition) begin m_state = 3; m_rem = 0; end
                   else if (expired) begin m_state = 2; m_rem = m_param[3] * TD; end
                2: if (ignition) begin m_state = 3; m_rem = 0; end
                   else if (any_open) m_rem = m_param[3] * TD;
                   else if (expired) m_state = 0;
                3: if (!ignition && door[0]) m_state = 4;
                4: if (ignition) m_state = 3;
                   else if (!any_open) begin m_state = 5; m_rem = m_param[0] * TD; end
                5: if (ignition) begin m_state = 3; m_rem = 0; end
                   else if (any_open) begin m_state = 4; m_rem = 0; end
                   else if (expired) m_state = 0;
                default: m_state = 0;
            endcase
        end
        if (m_state == 0) begin
            m_armed_cnt = (prev == 0) ? m_armed_cnt + 1 : 0;
            m_status = ((m_armed_cnt / TD) % 2) == 1;
        end else begin
            m_status = (m_state == 1) || (m_state == 2);
        end
        if (m_state == 2) begin
            if (prev != 2) begin
                m_alarm_cnt = 0;
                if (m_events < 255) m_events++;
            end else begin
                m_alarm_cnt++;
            end
            m_siren = ((m_alarm_cnt / (TD / 2)) % 2) == 0;
        end else begin
            m_siren = 0;
        end
        m_latch = ignition && (m_latch || (brake && hidden_sw));
        m_fuel  = m_latch;
    endtask

    task automatic check_model();
        chk("state",        state,        m_state);
        chk("timer_count",  timer_count,  (m_rem + TD - 1) / TD);
        chk("alarm_events", alarm_events, m_events);
        chk("status",       status,       m_status);
        chk("siren",        siren,        m_siren);
        chk("fuel_pump",    fuel_pump,    m_fuel);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_model();
    endtask

    task automatic prog(input logic [1:0] sel, input logic [3:0] val);
        param_sel = sel; param_value = val; reprogram = 1'b1;
        cycle();
        reprogram = 1'b0;
        cycle();
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        check_model();
        chk("rst_state", state, 0);
        chk("rst_fuel", fuel_pump, 0);
        repeat (3) cycle();
        chk("rst_status_3cyc", status, 0);
        cycle();
        chk("rst_status_4cyc", status, 1);

        // Passenger door pulse -> entry delay -> alarm
        door = 2'b10;
        cycle();
        chk("entry_state", state, 1);
        chk("entry_timer", timer_count, 15);
        door = 2'b00;
        repeat (59) cycle();
        chk("entry_59", state, 1);
        cycle();
        chk("alarm_60", state, 2);
        chk("alarm_events_1", alarm_events, 1);
        chk("siren_k0", siren, 1);
        cycle(); chk("siren_k1", siren, 1);
        cycle(); chk("siren_k2", siren, 0);
        cycle(); chk("siren_k3", siren, 0);
        cycle(); chk("siren_k4", siren, 1);

        // Door held open during alarm keeps reloading the alarm time
        door = 2'b01;
        repeat (20) begin
            cycle();
            chk("alarm_hold_timer", timer_count, 10);
        end
        door = 2'b00;
        repeat (39) cycle();
        chk("alarm_39", state, 2);
        cycle();
        chk("alarm_end_state", state, 0);
        chk("alarm_end_siren", siren, 0);

        // Arming sequence
        ignition = 1'b1; cycle(); chk("arm_disarmed", state, 3);
        ignition = 1'b0; door = 2'b01; cycle(); chk("arm_wait", state, 4);
        door = 2'b00; cycle(); chk("arm_delay", state, 5); chk("arm_timer", timer_count, 6);
        repeat (12) cycle(); chk("arm_count3", timer_count, 3);
        door = 2'b10; cycle(); chk("arm_reopen", state, 4); chk("arm_reopen_t", timer_count, 0);
        door = 2'b00; cycle(); chk("arm_redelay", state, 5); chk("arm_redelay_t", timer_count, 6);
        repeat (23) cycle(); chk("arm_23", state, 5);
        cycle(); chk("armed_again", state, 0);

        // Reprogram driver delay; zero write rejected
        param_sel = 2'd1; param_value = 4'd3; reprogram = 1'b1;
        cycle(); chk("rp_state", state, 0); chk("rp_timer", timer_count, 0);
        reprogram = 1'b0; cycle();
        door = 2'b01; cycle(); chk("rp_drv3", timer_count, 3);
        door = 2'b00; param_value = 4'd0; reprogram = 1'b1;
        cycle(); chk("rp0_state", state, 0); chk("rp0_timer", timer_count, 0);
        reprogram = 1'b0; cycle();
        door = 2'b01; cycle(); chk("rp0_drv_kept", timer_count, 3);
        door = 2'b00;

        // Fuel pump enable
        ignition = 1'b1; brake = 1'b1; cycle(); chk("fuel_brake_only", fuel_pump, 0);
        hidden_sw = 1'b1; cycle(); chk("fuel_on", fuel_pump, 1);
        brake = 1'b0; hidden_sw = 1'b0;
        repeat (3) cycle();
        chk("fuel_held", fuel_pump, 1);
        ignition = 1'b0; cycle(); chk("fuel_off", fuel_pump, 0);
        ignition = 1'b1; repeat (3) cycle(); chk("fuel_stays_off", fuel_pump, 0);
        ignition = 1'b0; cycle();

        // Alarm counter saturation with 1 s passenger and alarm times
        prog(2'd2, 4'd1);
        prog(2'd3, 4'd1);
        for (int i = 0; i < 260; i++) begin
            door = 2'b10; cycle();
            door = 2'b00; repeat (9) cycle();
        end
        chk("events_saturate", alarm_events, 255);

        // Asynchronous reset in the middle of an entry countdown
        door = 2'b10; cycle(); door = 2'b00;
        repeat (2) cycle();
        chk("pre_reset_entry", state, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_timer", timer_count, 0);
        chk("async_events", alarm_events, 0);
        chk("async_status", status, 0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (20) cycle();
        chk("post_reset_armed", state, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) ignition = ~ignition;
            if ($urandom_range(0, 7) == 0)
                door = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            brake     = ($urandom_range(0, 3) == 0);
            hidden_sw = ($urandom_range(0, 3) == 0);
            if (reprogram) begin
                reprogram = 1'b0;
            end else if ($urandom_range(0, 79) == 0) begin
                reprogram   = 1'b1;
                param_sel   = 2'($urandom_range(0, 3));
                param_value = 4'($urandom_range(0, 6));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/anti_theft_ctrl.md
ANTI_THEFT_CTRL -- requirements
Module: anti_theft_ctrl

Parameters
REQ-001 NUM_DOORS, 2, door inputs; door[0] is the driver door, all others passenger doors (range 1..8).
REQ-002 TW, 4, width of time parameters and timer count, in seconds.
REQ-003 TICK_DIV, 100_000_000, clock cycles per 1 s tick; even, >= 4.
REQ-004 T_ARM_DEF / T_DRV_DEF / T_PAS_DEF / T_ALM_DEF, 6 / 8 / 15 / 10, reset values of the four time parameters.

Interface
REQ-005 clock  in  1  single system clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 ignition, brake, hidden_sw  in  1 each  debounced, clock-synchronous levels.
REQ-008 door  in  NUM_DOORS  debounced door levels, 1 = open.
REQ-009 reprogram  in  1  level; its rising edge writes one time parameter.
REQ-010 param_sel  in  2  parameter index: 0 arm delay, 1 driver entry delay, 2 passenger entry delay, 3 alarm-on time.
REQ-011 param_value  in  TW  value to write.
REQ-012 fuel_pump, status, siren  out  1 each  registered outputs.
REQ-013 state  out  3  FSM state: ARMED=0, ENTRY_DELAY=1, ALARM=2, DISARMED=3, WAIT_CLOSE=4, ARM_DELAY=5.
REQ-014 timer_count  out  TW  remaining seconds.
REQ-015 alarm_events  out  8  alarm entry counter, saturating.

Function
REQ-016 Timer:
- a load writes a TW-bit value into timer_count and clears the tick prescaler;
- timer_count decrements on each TICK_DIV-cycle tick while non-zero;
- expired is a one-cycle internal pulse on the 1->0 step, so expiry occurs exactly value*TICK_DIV cycles after the load.
REQ-017 Reprogram edge:
- writes param_value into the register selected by param_sel;
- param_value==0 is rejected and the register keeps its old value;
- the write does not take effect until the next load that uses that parameter.
REQ-018 Transition priority per cycle: reprogram edge > ignition > doors > expired.
REQ-019 A reprogram edge, in any state, forces ARMED and clears timer_count to 0.
REQ-020 ARMED:
- ignition=1 -> DISARMED;
- else, if any door is open -> ENTRY_DELAY, loading the driver delay when door[0]=1, otherwise the passenger delay.
REQ-021 ENTRY_DELAY:
- ignition=1 -> DISARMED;
- expired -> ALARM;
- further door activity is ignored.
REQ-022 ALARM:
- ignition=1 -> DISARMED;
- while any door is open, the timer is reloaded with the alarm-on time every cycle;
- once all doors are closed, expired -> ARMED.
REQ-023 DISARMED: ignition=0 and door[0]=1 -> WAIT_CLOSE.
REQ-024 WAIT_CLOSE:
- ignition=1 -> DISARMED;
- all doors closed -> ARM_DELAY, loading the arm delay.
REQ-025 ARM_DELAY:
- ignition=1 -> DISARMED;
- any door open -> WAIT_CLOSE;
- expired -> ARMED.
REQ-026 Leaving a timed state by any path other than expiry clears timer_count to 0 in the same transition.
REQ-027 alarm_events increments by 1 on each entry into ALARM and saturates at 255.
REQ-028 siren:
- while in ALARM, toggles every TICK_DIV/2 cycles, starting at 1 in the first ALARM cycle;
- 0 in every other state, updated in the cycle the FSM leaves ALARM.
REQ-029 status:
- ARMED: toggles on each tick, starting at 0 on entry;
- ENTRY_DELAY and ALARM: constant 1;
- all other states: 0.
REQ-030 fuel_pump:
- an internal enable latch sets when ignition=1, brake=1 and hidden_sw=1 in the same cycle;
- the latch clears in any cycle with ignition=0;
- fuel_pump = registered (ignition AND latch);
- fuel_pump is independent of the FSM state.
REQ-031 Every output changes only on a rising clock edge (registered), apart from the asynchronous reset in REQ-032.

Reset
REQ-032 reset=0 asynchronously forces:
- state=ARMED;
- timer_count=0, alarm_events=0;
- siren=0, status=0, fuel_pump=0, enable latch cleared, prescalers cleared;
- time parameters set to their *_DEF values.
REQ-033 Reset deasserting mid-countdown or mid-alarm resumes from the reset state only; no pending expiry survives reset.

Verification (TICK_DIV=4, defaults otherwise)
REQ-034 Reset released with all inputs 0 -> state=0, all outputs 0; after 4 cycles status=1.
REQ-035 In ARMED, pulse door[1] for 1 cycle ->
- state=1 with timer_count=15;
- state=2 exactly 60 cycles later, alarm_events=1;
- siren toggles every 2 cycles.
REQ-036 In ALARM, hold door[0] open for 20 cycles, then close all doors ->
- timer_count stays at 10 while the door is open;
- state=0 exactly 40 cycles after the close;
- siren=0.
REQ-037 Arming sequence: ignition=1 -> state=3; ignition=0, door[0] 1 then 0 -> state=4 then 5 with timer_count=6; door[1] opens at count 3 -> state=4; close -> state=5 with timer_count=6; 24 cycles later -> state=0.
REQ-038 Reprogram edge with param_sel=1, param_value=3 -> state=0, timer_count=0; then door[0] open -> timer_count=3; a write with param_value=0 leaves the value at 3.
REQ-039 Fuel pump:
- ignition=1 with brake=1 alone -> fuel_pump=0;
- adding hidden_sw=1 -> fuel_pump=1 next cycle;
- releasing brake and hidden_sw keeps fuel_pump=1;
- ignition=0 -> fuel_pump=0, and it stays 0 when ignition returns to 1.
